bmc_soft_pipe: RTL and testbench

- Parametrised branch-metric unit for a rate-1/N convolutional Viterbi decoder.
- Computes one metric per codeword hypothesis (2^N of them) from N soft-decision received samples.
- Supports per-bit erasure masks for punctured codes.
- Two-stage pipeline with valid/ready backpressure.
- Sits between the depuncturer/quantiser and the ACS array.
- Generalises the fixed 2-bit hard-decision BMCs. With SW=1 and no erasures, metric = Hamming distance, identical to the legacy {and, xor} encoding.

---
 rtl/vd_pkg.sv | 14 +
 rtl/bmc_soft_dist.sv | 12 +
 rtl/bmc_soft_pipe.sv | 83 ++++++++
 tb/tb_bmc_soft_pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vd_pkg.sv
// vd_pkg: shared soft-sample conventions and metric sizing for the Viterbi decoder blocks.
package vd_pkg;
   localparam int SOFT_ZERO = 0;
   typedef int unsigned slice_t;
   function automatic int soft_one(input int sw);
      return (1 << sw) - 1;
   endfunction
   function automatic int bmc_metric_width(input int n, input int sw);
      return $clog2(n * soft_one(sw) + 1);
   endfunction
   function automatic slice_t slice_lo(input slice_t idx, input slice_t w);
      return idx * w;
   endfunction
endpackage

// File: rtl/bmc_soft_dist.sv
// bmc_soft_dist: per-sample distances to an expected '0' and '1'; punctured samples contribute nothing.
module bmc_soft_dist import vd_pkg::*; #(
   parameter int SW = 3
) (
   input  logic [SW-1:0] rx,
   input  logic          erase,
   output logic [SW-1:0] d0,
   output logic [SW-1:0] d1
);
   assign d0 = erase ? SW'(SOFT_ZERO) : rx;
   assign d1 = erase ? SW'(SOFT_ZERO) : SW'(soft_one(SW)) - rx;
endmodule

// File: rtl/bmc_soft_pipe.sv
// bmc_soft_pipe: two-stage soft-decision branch-metric unit, one metric per codeword hypothesis,
// with valid/ready backpressure and a per-frame output symbol counter.
module bmc_soft_pipe import vd_pkg::*; #(
   parameter int CODE_N = 2,
   parameter int SW     = 3,
   parameter int CNT_W  = 16
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic                                                   in_valid,
   output logic                                                   in_ready,
   input  logic [CODE_N*SW-1:0]                                   in_soft,
   input  logic [CODE_N-1:0]                                      in_erase,
   input  logic                                                   in_last,
   output logic                                                   out_valid,
   input  logic                                                   out_ready,
   output logic [(2**CODE_N)*bmc_metric_width(CODE_N, SW)-1:0]    out_metric,
   output logic                                                   out_last,
   output logic [CNT_W-1:0]                                       out_sym_cnt
);
   localparam int MW = bmc_metric_width(CODE_N, SW);
   localparam int NH = 2 ** CODE_N;
   logic w_adv1, w_adv2;
   logic [CODE_N-1:0][SW-1:0] w_d0, w_d1, r_d0, r_d1;
   logic r_s1_v, r_s1_last, r_s2_v, r_s2_last;
   logic [NH*MW-1:0] w_metric, r_metric;
   logic [CNT_W-1:0] r_cnt;

   assign w_adv2      = !r_s2_v || out_ready;
   assign w_adv1      = !r_s1_v || w_adv2;
   assign in_ready    = w_adv1;
   assign out_valid   = r_s2_v;
   assign out_metric  = r_metric;
   assign out_last    = r_s2_last;
   assign out_sym_cnt = r_cnt;

   for (genvar g = 0; g < CODE_N; g++) begin : g_dist
      bmc_soft_dist #(.SW(SW)) u_dist (
         .rx   (in_soft[g*SW +: SW]),
         .erase(in_erase[g]),
         .d0   (w_d0[g]),
         .d1   (w_d1[g])
      );
   end

   // Bit j of hypothesis h selects which stored distance sample j contributes.
   for (genvar h = 0; h < NH; h++) begin : g_hyp
      logic [MW-1:0] w_sum;
      always_comb begin
         w_sum = '0;
         for (int j = 0; j < CODE_N; j++)
            w_sum = w_sum + MW'(((h >> j) & 1) == 1 ? r_d1[j] : r_d0[j]);
      end
      assign w_metric[slice_lo(h, MW) +: MW] = w_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_v    <= 1'b0;
         r_s1_last <= 1'b0;
         r_d0      <= '0;
         r_d1      <= '0;
         r_s2_v    <= 1'b0;
         r_s2_last <= 1'b0;
         r_metric  <= '0;
         r_cnt     <= '0;
      end else begin
         if (w_adv1) begin
            r_s1_v    <= in_valid;
            r_s1_last <= in_last;
            r_d0      <= w_d0;
            r_d1      <= w_d1;
         end
         if (w_adv2) begin
            r_s2_v    <= r_s1_v;
            r_s2_last <= r_s1_last;
            r_metric  <= w_metric;
         end
         if (r_s2_v && out_ready)
            r_cnt <= r_s2_last ? '0 : r_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// tb_bmc_soft_pipe: directed checks of the soft BMC (N=2, SW=3) plus a hard-decision (SW=1) instance.
module tb_bmc_soft_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [5:0]  in_soft = '0;
   logic [1:0]  in_erase = '0;
   logic        in_ready, out_valid, out_last;
   logic [15:0] out_metric;
   logic [15:0] out_sym_cnt;
   logic        h_in_valid = 1'b0, h_in_last = 1'b0;
   logic [1:0]  h_in_soft = '0, h_in_erase = '0;
   logic        h_in_ready, h_out_valid, h_out_last;
   logic [7:0]  h_out_metric;
   logic [15:0] h_out_sym_cnt;
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   bmc_soft_pipe #(.CODE_N(2), .SW(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_soft(in_soft),
      .in_erase(in_erase), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_metric(out_metric), .out_last(out_last), .out_sym_cnt(out_sym_cnt)
   );

   bmc_soft_pipe #(.CODE_N(2), .SW(1), .CNT_W(16)) dut_hard (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_soft(h_in_soft),
      .in_erase(h_in_erase), .in_last(h_in_last), .out_valid(h_out_valid), .out_ready(out_ready),
      .out_metric(h_out_metric), .out_last(h_out_last), .out_sym_cnt(h_out_sym_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_erase = '0; out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
      total++; if (out_metric !== 16'h0) $display("FAIL rst_metric: got %h want 0000", out_metric); else passed++;
      total++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b want 0", out_last); else passed++;
      total++; if (out_sym_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", out_sym_cnt); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
      total++; if (h_out_valid !== 1'b0) $display("FAIL rst_hard_valid: got %b want 0", h_out_valid); else passed++;
   endtask

   task automatic test_basic();
      do_reset();
      in_valid = 1'b1; in_soft = 6'b000_111;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL basic_early: got %b want 0", out_valid); else passed++;
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_metric !== 16'h7E07) $display("FAIL basic_metric: got %h want 7e07", out_metric); else passed++;
      total++; if (out_sym_cnt !== 16'd0) $display("FAIL basic_cnt: got %0d want 0", out_sym_cnt); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_erasure();
      do_reset();
      in_valid = 1'b1; in_soft = 6'b000_111; in_erase = 2'b01;
      step();
      in_erase = 2'b11;
      step();
      in_valid = 1'b0; in_erase = 2'b00;
      total++; if (out_metric !== 16'h7700) $display("FAIL erase01_metric: got %h want 7700", out_metric); else passed++;
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL erase11_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_metric !== 16'h0000) $display("FAIL erase11_metric: got %h want 0000", out_metric); else passed++;
      total++; if (out_sym_cnt !== 16'd1) $display("FAIL erase11_cnt: got %0d want 1", out_sym_cnt); else passed++;
      step();
   endtask

   task automatic test_back_to_back();
      do_reset();
      in_valid = 1'b1; in_soft = 6'b000_111;
      step();
      in_soft = 6'b111_000;
      step();
      total++; if (out_metric !== 16'h7E07) $display("FAIL bp_a_arrive: got %h want 7e07", out_metric); else passed++;
      in_soft = 6'b011_101; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (out_metric !== 16'h7E07 || out_valid !== 1'b1) $display("FAIL bp_a_hold%0d: got %b/%h want 1/7e07", k, out_valid, out_metric); else passed++;
         total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); else passed++;
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", in_ready); else passed++;
      step();
      in_valid = 1'b0;
      total++; if (out_metric !== 16'h70E7 || out_sym_cnt !== 16'd1) $display("FAIL bp_b: got %h cnt %0d want 70e7 cnt 1", out_metric, out_sym_cnt); else passed++;
      step();
      total++; if (out_metric !== 16'h6958 || out_sym_cnt !== 16'd2) $display("FAIL bp_c: got %h cnt %0d want 6958 cnt 2", out_metric, out_sym_cnt); else passed++;
      step();
      total++; if (out_valid !== 1'b0 || out_sym_cnt !== 16'd3) $display("FAIL bp_drain: got %b cnt %0d want 0 cnt 3", out_valid, out_sym_cnt); else passed++;
   endtask

   task automatic test_frame();
      do_reset();
      for (int j = 0; j < 6; j++) begin
         in_valid = (j < 5);
         in_last  = (j == 3);
         in_soft  = 6'(j * 9);
         step();
         if (j >= 1) begin
            total++;
            if (out_valid !== 1'b1 || out_sym_cnt !== 16'((j - 1) == 4 ? 0 : j - 1) || out_last !== ((j - 1) == 3))
               $display("FAIL frame_sym%0d: got v%b cnt %0d last %b want v1 cnt %0d last %b",
                        j - 1, out_valid, out_sym_cnt, out_last, (j - 1) == 4 ? 0 : j - 1, (j - 1) == 3);
            else passed++;
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1'b1; in_soft = 6'b000_111;
      step();
      in_valid = 1'b0;
      step();
      step();
      total++; if (out_sym_cnt !== 16'd1) $display("FAIL mid_pre_cnt: got %0d want 1", out_sym_cnt); else passed++;
      out_ready = 1'b0; in_valid = 1'b1; in_soft = 6'b111_000;
      step();
      in_soft = 6'b011_101;
      step();
      in_valid = 1'b0; rst = 1'b1;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else passed++;
      total++; if (out_sym_cnt !== 16'd0) $display("FAIL mid_cnt: got %0d want 0", out_sym_cnt); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else passed++;
      rst = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (out_valid !== 1'b0) $display("FAIL mid_stale%0d: got %b want 0", k, out_valid); else passed++;
      end
   endtask

   task automatic test_hard();
      logic [1:0] exp;
      do_reset();
      for (int r = 0; r < 4; r++) begin
         h_in_valid = 1'b1; h_in_soft = 2'(r);
         step();
         h_in_valid = 1'b0;
         step();
         for (int h = 0; h < 4; h++) begin
            exp = 2'($countones(2'(r) ^ 2'(h)));
            total++;
            if (h_out_valid !== 1'b1 || h_out_metric[h*2 +: 2] !== exp)
               $display("FAIL hard_rx%0d_h%0d: got v%b m%0d want v1 m%0d", r, h, h_out_valid, h_out_metric[h*2 +: 2], exp);
            else passed++;
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_erasure();
      test_back_to_back();
      test_frame();
      test_reset_mid();
      test_hard();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
